lfsr_prbs_gen: RTL

Parametrised PRBS source for error-injection and BER test paths. It generalises the single-step Fibonacci LFSR with the following additions:
- Fibonacci/Galois selection
- multiple steps per clock
- runtime seed load
- valid/ready output handshake
- period measurement against the loaded seed

It drives pattern streams into the error-analysis datapath and the checker side.

---
 rtl/lfsr_prbs_gen_if.sv | 12 +
 rtl/lfsr_prbs_gen.sv | 102 ++++++++++
 2 files changed

// File: rtl/lfsr_prbs_gen_if.sv
// Pattern-beat handshake bundle for lfsr_prbs_gen: q/out_valid from the
// generator, out_ready from the consumer.
interface lfsr_prbs_gen_if #(
  parameter int N = 3
);
  logic [N-1:0] q;
  logic         out_valid;
  logic         out_ready;

  modport master (output q, output out_valid, input out_ready);
  modport slave  (input q, input out_valid, output out_ready);
endinterface

// File: rtl/lfsr_prbs_gen.sv
// Parametrised Fibonacci/Galois PRBS source with multi-step beats, seed load,
// valid/ready output and period measurement. Optional macro: LFSR_LOCKUP_RECOVER_EN.
module lfsr_prbs_gen #(
  parameter int              N     = 3,
  parameter logic [N-1:0]    TAPS  = N'(3),
  parameter logic [N-1:0]    SEED  = N'(1),
  parameter int unsigned     MODE  = 0,
  parameter int unsigned     STEPS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               seed_load,
  input  logic [N-1:0]       seed_in,
  lfsr_prbs_gen_if.master    bus,
  output logic               period_done,
  output logic [N-1:0]       period_len,
  output logic               lockup
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] state;
  logic [N-1:0] ref_seed;
  logic [N-1:0] cnt;
  logic         out_valid;
  logic         accept;
  logic [N-1:0] succ;
  logic [N-1:0] next_state;
  logic [N-1:0] load_val;

  function automatic logic [N-1:0] step1(input logic [N-1:0] s);
    if (MODE == 0)
      return {^(s & TAPS), s[N-1:1]};
    else
      return {1'b0, s[N-1:1]} ^ ({N{s[0]}} & TAPS);
  endfunction

  assign bus.q         = state;
  assign bus.out_valid = out_valid;
  assign accept        = out_valid & bus.out_ready;

  always_comb begin
    succ = state;
    for (int unsigned i = 0; i < STEPS; i++)
      succ = step1(succ);
  end

`ifdef LFSR_LOCKUP_RECOVER_EN
  logic step_zero;
  logic load_zero;

  // Zero is absorbing for both structures, so checking only the final
  // unrolled successor catches any intermediate collapse too.
  assign step_zero  = (succ == '0);
  assign load_zero  = (seed_in == '0);
  assign next_state = step_zero ? SEED : succ;
  assign load_val   = load_zero ? SEED : seed_in;

  always_ff @(posedge clk) begin
    if (reset)
      lockup <= 1'b0;
    else if (seed_load)
      lockup <= load_zero;
    else
      lockup <= accept & step_zero;
  end
`else
  assign next_state = succ;
  assign load_val   = seed_in;
  assign lockup     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SEED;
      ref_seed    <= SEED;
      cnt         <= '0;
      out_valid   <= 1'b0;
      period_done <= 1'b0;
      period_len  <= '0;
    end else begin
      out_valid   <= en & ~seed_load;
      period_done <= 1'b0;
      if (seed_load) begin
        state    <= load_val;
        ref_seed <= load_val;
        cnt      <= '0;
      end else if (accept) begin
        state <= next_state;
        if (next_state == ref_seed) begin
          period_done <= 1'b1;
          period_len  <= cnt + ONE;
          cnt         <= '0;
        end else begin
          cnt <= cnt + ONE;
        end
      end
    end
  end

endmodule
